// File: rtl/router_reg_param.sv
// Router datapath register: captures header/payload/parity and forwards words to the destination FIFO.
// Words that cannot go out immediately wait in a small circular holding buffer until the FIFO drains.
module router_reg_param #(
  parameter int unsigned DW         = 8,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pkt_valid,
  input  logic [DW-1:0]                 data_in,
  input  logic                          fifo_full,
  input  logic                          detect_add,
  input  logic                          lfd_state,
  input  logic                          ld_state,
  input  logic                          laf_state,
  input  logic                          full_state,
  input  logic                          rst_int_reg,
  output logic [DW-1:0]                 data_out,
  output logic                          dout_valid,
  output logic                          parity_done,
  output logic                          low_pkt_valid,
  output logic                          parity_err,
  output logic                          len_err,
  output logic                          ovf_err,
  output logic [$clog2(SKID_DEPTH):0]   skid_count,
  output logic                          skid_full
);

  localparam int unsigned LW = DW - 2;
  localparam int unsigned CW = $clog2(SKID_DEPTH) + 1;
  localparam int unsigned PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(SKID_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(SKID_DEPTH);

  typedef enum logic [2:0] {
    SEL_IDLE,
    SEL_LFD,
    SEL_LD,
    SEL_LAF,
    SEL_FULL
  } sel_e;

  sel_e sel;

  logic [DW-1:0] header_q, header_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] len_cnt_q, len_cnt_d;
  logic [DW-1:0] int_par_q, int_par_d;
  logic [DW-1:0] pkt_par_q, pkt_par_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          dout_valid_q, dout_valid_d;
  logic          parity_done_q, parity_done_d;
  logic          done_rise_q, done_rise_d;
  logic          low_pkt_valid_q, low_pkt_valid_d;
  logic          parity_err_q, parity_err_d;
  logic          len_err_q, len_err_d;
  logic          ovf_err_q, ovf_err_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mem_q [SKID_DEPTH];
  logic [DW-1:0] mem_d [SKID_DEPTH];

  logic hdr_cap;
  logic buf_empty;
  logic buf_full;
  logic push;
  logic pop;
  logic capture;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Controller state priority; full_state only ever means "hold".
  always_comb begin
    sel = SEL_IDLE;
    if (lfd_state)       sel = SEL_LFD;
    else if (ld_state)   sel = SEL_LD;
    else if (laf_state)  sel = SEL_LAF;
    else if (full_state) sel = SEL_FULL;
  end

  assign hdr_cap   = detect_add & pkt_valid;
  assign buf_empty = (cnt_q == '0);
  assign buf_full  = (cnt_q == FULL_CNT);

  always_comb begin
    header_d        = header_q;
    len_d           = len_q;
    len_cnt_d       = len_cnt_q;
    int_par_d       = int_par_q;
    pkt_par_d       = pkt_par_q;
    data_out_d      = data_out_q;
    dout_valid_d    = 1'b0;
    parity_done_d   = parity_done_q;
    done_rise_d     = 1'b0;
    low_pkt_valid_d = low_pkt_valid_q;
    parity_err_d    = parity_err_q;
    len_err_d       = len_err_q;
    ovf_err_d       = ovf_err_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    cnt_d           = cnt_q;
    mem_d           = mem_q;
    push            = 1'b0;
    pop             = 1'b0;
    capture         = 1'b0;

    if (done_rise_q) begin
      parity_err_d = (int_par_q != pkt_par_q);
      len_err_d    = (len_cnt_q != len_q);
    end

    case (sel)
      SEL_LFD: begin
        data_out_d   = header_q;
        dout_valid_d = 1'b1;
        int_par_d    = int_par_q ^ header_q;
      end
      SEL_LD: begin
        if (pkt_valid) begin
          int_par_d = int_par_q ^ data_in;
          len_cnt_d = (len_cnt_q == '1) ? len_cnt_q : len_cnt_q + 1'b1;
        end else begin
          pkt_par_d       = data_in;
          low_pkt_valid_d = 1'b1;
          capture         = 1'b1;
        end
        // Bypass only when nothing is queued, so FIFO order is kept.
        if (!fifo_full && buf_empty) begin
          data_out_d   = data_in;
          dout_valid_d = 1'b1;
        end else begin
          push = 1'b1;
        end
      end
      SEL_LAF: begin
        if (!fifo_full && !buf_empty) pop = 1'b1;
      end
      default: ;
    endcase

    if (push) begin
      if (buf_full) begin
        ovf_err_d = 1'b1;
      end else begin
        mem_d[wr_ptr_q] = data_in;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
        cnt_d           = cnt_q + 1'b1;
      end
    end

    if (pop) begin
      data_out_d   = mem_q[rd_ptr_q];
      dout_valid_d = 1'b1;
      rd_ptr_d     = ptr_inc(rd_ptr_q);
      cnt_d        = cnt_q - 1'b1;
    end

    if (!hdr_cap && !parity_done_q && (low_pkt_valid_q || capture) && buf_empty && !push) begin
      parity_done_d = 1'b1;
      done_rise_d   = 1'b1;
    end

    if (hdr_cap) begin
      header_d      = data_in;
      len_d         = data_in[DW-1:2];
      len_cnt_d     = '0;
      int_par_d     = '0;
      parity_done_d = 1'b0;
      parity_err_d  = 1'b0;
      len_err_d     = 1'b0;
    end

    if (rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
      pkt_par_d       = '0;
      int_par_d       = '0;
      ovf_err_d       = 1'b0;
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      cnt_d           = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      header_q        <= '0;
      len_q           <= '0;
      len_cnt_q       <= '0;
      int_par_q       <= '0;
      pkt_par_q       <= '0;
      data_out_q      <= '0;
      dout_valid_q    <= 1'b0;
      parity_done_q   <= 1'b0;
      done_rise_q     <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      parity_err_q    <= 1'b0;
      len_err_q       <= 1'b0;
      ovf_err_q       <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      header_q        <= header_d;
      len_q           <= len_d;
      len_cnt_q       <= len_cnt_d;
      int_par_q       <= int_par_d;
      pkt_par_q       <= pkt_par_d;
      data_out_q      <= data_out_d;
      dout_valid_q    <= dout_valid_d;
      parity_done_q   <= parity_done_d;
      done_rise_q     <= done_rise_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      parity_err_q    <= parity_err_d;
      len_err_q       <= len_err_d;
      ovf_err_q       <= ovf_err_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_q           <= cnt_d;
      mem_q           <= mem_d;
    end
  end

  assign data_out      = data_out_q;
  assign dout_valid    = dout_valid_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign parity_err    = parity_err_q;
  assign len_err       = len_err_q;
  assign ovf_err       = ovf_err_q;
  assign skid_count    = cnt_q;
  assign skid_full     = buf_full;

endmodule

// File: doc/router_reg_param.md
ROUTER_REG_PARAM -- requirements
Module: router_reg_param

Interface
REQ-001 Parameter DW, default 8, data word width in bits (minimum 4).
REQ-002 Parameter SKID_DEPTH, default 2, holding-buffer depth in words (power of 2, minimum 1).
REQ-003 Header format SHALL be: bits [1:0] destination address, bits [DW-1:2] payload length LEN (words).
REQ-004 clk  input  1  single clock, all state updated on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pkt_valid  input  1  high for header and payload words, low for the parity word.
REQ-007 data_in  input  DW  incoming packet word.
REQ-008 fifo_full  input  1  destination FIFO cannot accept a word this cycle.
REQ-009 detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  input  1 each  controller state indications.
REQ-010 data_out  output  DW  word presented to the destination FIFO.
REQ-011 dout_valid  output  1  one-cycle pulse: data_out carries a new word this cycle.
REQ-012 parity_done  output  1  packet fully forwarded and parity word captured.
REQ-013 low_pkt_valid  output  1  parity word has arrived (pkt_valid fell in ld_state).
REQ-014 parity_err, len_err, ovf_err  output  1 each  parity mismatch, length mismatch, holding-buffer overflow.
REQ-015 skid_count  output  clog2(SKID_DEPTH)+1  occupancy of the holding buffer; skid_full  output  1  occupancy == SKID_DEPTH.

Function
REQ-016 State-input priority SHALL be lfd_state > ld_state > laf_state; full_state alone SHALL cause no register change except holding.
REQ-017 detect_add && pkt_valid: capture data_in as header, LEN = data_in[DW-1:2], clear length counter, internal parity, parity_done, parity_err, len_err.
REQ-018 lfd_state: data_out <= header, dout_valid = 1 next cycle, internal parity ^= header.
REQ-019 ld_state && pkt_valid: internal parity ^= data_in; length counter +1, saturating at all-ones.
REQ-020 ld_state, any pkt_valid: if !fifo_full and skid_count == 0, data_out <= data_in with dout_valid; otherwise push data_in into the holding buffer.
REQ-021 Push while skid_full: word dropped, ovf_err set; ovf_err sticky until reset or rst_int_reg.
REQ-022 ld_state && !pkt_valid: packet parity register <= data_in; low_pkt_valid <= 1; parity word not XORed, not counted.
REQ-023 laf_state && !fifo_full && skid_count != 0: pop oldest word (FIFO order) to data_out with dout_valid; at most one pop per cycle.
REQ-024 Holding buffer SHALL be circular, pointers wrapping at SKID_DEPTH; no push and pop in the same cycle (ld/laf exclusive per REQ-016).
REQ-025 parity_done <= 1 on the first cycle in which the parity word is captured (or already held) and skid_count == 0 with no push that cycle; stays 1 until detect_add.
REQ-026 One cycle after parity_done rises: parity_err <= (internal parity != packet parity); len_err <= (length counter != LEN); both held until next detect_add.
REQ-027 rst_int_reg: clear low_pkt_valid, packet parity, internal parity, ovf_err, and flush holding buffer (skid_count = 0).
REQ-028 dout_valid SHALL be low in every cycle not named in REQ-018/020/023; data_out holds its last value.

Reset
REQ-029 reset high SHALL immediately clear data_out, dout_valid, parity_done, low_pkt_valid, all error flags, header, LEN, counters, parity registers, buffer pointers (skid_count = 0), independent of clk.
REQ-030 reset asserted mid-packet SHALL abandon the packet; after release the block SHALL accept a new header with no residual state.

Verification
REQ-031 DW=8: header 0x0D, payload 0x11,0x22,0x33, parity 0x0D, fifo_full=0 -> 5 dout_valid pulses (0x0D,0x11,0x22,0x33,0x0D), parity_err=0, len_err=0.
REQ-032 Same packet with parity 0xFF -> parity_err=1, len_err=0 one cycle after parity_done.
REQ-033 Header 0x0D, payload 0x11,0x22, parity 0x3E -> len_err=1, parity_err=0.
REQ-034 SKID_DEPTH=2, fifo_full=1 during 0x22,0x33 -> skid_count=2, skid_full=1; laf_state with fifo_full=0 -> pops 0x22 then 0x33, then parity_done=1.
REQ-035 Buffer full, third word 0x44 pushed -> 0x44 dropped, ovf_err=1, skid_count stays 2.
REQ-036 reset pulsed between clock edges mid-payload -> all outputs 0 before next edge; following clean packet passes REQ-031.
